rvlab_mmcm_drp_seq: RTL

Hardware sequencer that retunes CLKOUT0 of the system MMCM through its DRP port. A single integer divider request triggers the full sequence: assert MMCM reset, read-modify-write ClkReg1 (0x08) and ClkReg2 (0x09), release reset, then wait for lock. DRP and lock waits are bounded by timeouts. The block sits between the TL-UL register front-end and the MMCM DRP pins, in the board (DRP) clock domain.

---
 rtl/rvlab_mmcm_drp_seq_if.sv | 31 +++
 rtl/rvlab_mmcm_drp_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rvlab_mmcm_drp_seq_if.sv
// Request/status and MMCM DRP pin bundle for the CLKOUT0 retune sequencer.
// slave = sequencer side, master = register front-end / MMCM side.
interface rvlab_mmcm_drp_seq_if;
    logic        req_valid_i;
    logic [6:0]  req_div_i;
    logic        req_ready_o;
    logic        drp_en_o;
    logic        drp_we_o;
    logic [6:0]  drp_adr_o;
    logic [15:0] drp_di_o;
    logic        drp_rdy_i;
    logic [15:0] drp_do_i;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;
    logic [6:0]  cur_div_o;

    modport slave (
        input  req_valid_i, req_div_i, drp_rdy_i, drp_do_i, mmcm_locked_i,
        output req_ready_o, drp_en_o, drp_we_o, drp_adr_o, drp_di_o,
               mmcm_rst_o, busy_o, done_o, err_o, cur_div_o
    );

    modport master (
        output req_valid_i, req_div_i, drp_rdy_i, drp_do_i, mmcm_locked_i,
        input  req_ready_o, drp_en_o, drp_we_o, drp_adr_o, drp_di_o,
               mmcm_rst_o, busy_o, done_o, err_o, cur_div_o
    );
endinterface

// File: rtl/rvlab_mmcm_drp_seq.sv
// Purpose: retunes MMCM CLKOUT0 divide via DRP read-modify-write of ClkReg1/ClkReg2 under MMCM reset.
// Latency: RST_HOLD + 4 x (issue + response) + 1 + lock time + 1 cycles from accept to done_o.
// Backpressure: req_ready_o only in IDLE; requests while busy are dropped, DRP/lock waits time out.
module rvlab_mmcm_drp_seq #(
    parameter int unsigned DEFAULT_DIV  = 18,
    parameter int unsigned DRP_TIMEOUT  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned RST_HOLD     = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rvlab_mmcm_drp_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RD1,
        S_WR1,
        S_RD2,
        S_WR2,
        S_RELEASE,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    localparam logic [6:0] ADR_CLKREG1 = 7'h08;
    localparam logic [6:0] ADR_CLKREG2 = 7'h09;

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [6:0]  div_q, div_d;
    logic        drp_en_q, drp_en_d;
    logic        drp_we_q, drp_we_d;
    logic [6:0]  drp_adr_q, drp_adr_d;
    logic [15:0] drp_di_q, drp_di_d;
    logic        mmcm_rst_q, mmcm_rst_d;
    logic [1:0]  err_q, err_d;
    logic [6:0]  cur_div_q, cur_div_d;
    logic        rdy_ok;

    // ClkReg1: keep only reserved bit 12, phase mux forced to 0, high/low counts.
    function automatic logic [15:0] clkreg1_merge(input logic [15:0] rd, input logic [6:0] d);
        logic [5:0] hi;
        logic [5:0] lo;
        if (d == 7'd1) begin
            hi = 6'd1;
            lo = 6'd1;
        end else begin
            hi = d[6:1];
            lo = 6'(d - {1'b0, d[6:1]});
        end
        return (rd & 16'h1000) | {4'b0000, hi, lo};
    endfunction

    function automatic logic [15:0] clkreg2_merge(input logic [15:0] rd, input logic [6:0] d);
        logic edge_b;
        logic no_count;
        no_count = (d == 7'd1);
        edge_b   = d[0] & ~no_count;
        return (rd & 16'hFC00) | {8'h00, edge_b, no_count, 6'h00};
    endfunction

    // A response in the same cycle as our own enable pulse cannot belong to it.
    assign rdy_ok = bus.drp_rdy_i & ~drp_en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_q      <= '0;
            drp_en_q   <= 1'b0;
            drp_we_q   <= 1'b0;
            drp_adr_q  <= '0;
            drp_di_q   <= '0;
            mmcm_rst_q <= 1'b0;
            err_q      <= 2'd0;
            cur_div_q  <= 7'(DEFAULT_DIV);
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            div_q      <= div_d;
            drp_en_q   <= drp_en_d;
            drp_we_q   <= drp_we_d;
            drp_adr_q  <= drp_adr_d;
            drp_di_q   <= drp_di_d;
            mmcm_rst_q <= mmcm_rst_d;
            err_q      <= err_d;
            cur_div_q  <= cur_div_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        div_d      = div_q;
        drp_en_d   = 1'b0;
        drp_we_d   = drp_we_q;
        drp_adr_d  = drp_adr_q;
        drp_di_d   = drp_di_q;
        mmcm_rst_d = mmcm_rst_q;
        err_d      = err_q;
        cur_div_d  = cur_div_q;

        case (state)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    div_d = bus.req_div_i;
                    cnt_d = '0;
                    if (bus.req_div_i == 7'd0 || bus.req_div_i == 7'h7F) begin
                        err_d   = 2'd1;
                        state_d = S_DONE;
                    end else begin
                        err_d      = 2'd0;
                        mmcm_rst_d = 1'b1;
                        state_d    = S_RST_HOLD;
                    end
                end
            end

            S_RST_HOLD: begin
                cnt_d = cnt + 16'd1;
                if (cnt == 16'(RST_HOLD - 1)) begin
                    cnt_d     = '0;
                    drp_en_d  = 1'b1;
                    drp_we_d  = 1'b0;
                    drp_adr_d = ADR_CLKREG1;
                    state_d   = S_RD1;
                end
            end

            S_RD1, S_WR1, S_RD2, S_WR2: begin
                cnt_d = cnt + 16'd1;
                if (rdy_ok) begin
                    cnt_d    = '0;
                    drp_en_d = 1'b1;
                    case (state)
                        S_RD1: begin
                            drp_we_d  = 1'b1;
                            drp_adr_d = ADR_CLKREG1;
                            drp_di_d  = clkreg1_merge(bus.drp_do_i, div_q);
                            state_d   = S_WR1;
                        end
                        S_WR1: begin
                            drp_we_d  = 1'b0;
                            drp_adr_d = ADR_CLKREG2;
                            state_d   = S_RD2;
                        end
                        S_RD2: begin
                            drp_we_d  = 1'b1;
                            drp_adr_d = ADR_CLKREG2;
                            drp_di_d  = clkreg2_merge(bus.drp_do_i, div_q);
                            state_d   = S_WR2;
                        end
                        default: begin
                            drp_en_d   = 1'b0;
                            drp_we_d   = 1'b0;
                            mmcm_rst_d = 1'b0;
                            state_d    = S_RELEASE;
                        end
                    endcase
                end else if (cnt == 16'(DRP_TIMEOUT - 1)) begin
                    // Registers may be half written; let the MMCM run anyway.
                    drp_we_d   = 1'b0;
                    mmcm_rst_d = 1'b0;
                    err_d      = 2'd2;
                    state_d    = S_DONE;
                end
            end

            S_RELEASE: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end

            S_WAIT_LOCK: begin
                cnt_d = cnt + 16'd1;
                if (bus.mmcm_locked_i) begin
                    cur_div_d = div_q;
                    err_d     = 2'd0;
                    state_d   = S_DONE;
                end else if (cnt == 16'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 2'd3;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready_o = (state == S_IDLE);
    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = (state == S_DONE);
    assign bus.drp_en_o    = drp_en_q;
    assign bus.drp_we_o    = drp_we_q;
    assign bus.drp_adr_o   = drp_adr_q;
    assign bus.drp_di_o    = drp_di_q;
    assign bus.mmcm_rst_o  = mmcm_rst_q;
    assign bus.err_o       = err_q;
    assign bus.cur_div_o   = cur_div_q;

endmodule
